sar_conv_sequencer: RTL and testbench

Sequences the 8-bit SAR conversion engine at a programmable sample rate. It issues `cnvst` pulses from a period timer, waits for `eoc`, and captures the 8-bit result. It can average 1/2/4/8 conversions before emitting a sample into a small output FIFO with a valid/ready handshake. The block sits between the SAR logic and the downstream digital consumer, and reports overrun, late-trigger and timeout errors.

---
 rtl/sar_pkg.sv | 15 +
 rtl/sar_result_fifo.sv | 56 +++++
 rtl/sar_conv_sequencer.sv | 159 +++++++++++++++
 tb/tb_sar_conv_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and widths for the SAR conversion sequencer and its result FIFO.
package sar_pkg;

  localparam int SAR_W = 8;
  localparam int ACC_W = SAR_W + 3;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_CONV,
    ST_PUSH
  } seq_state_e;

endpackage

// File: rtl/sar_result_fifo.sv
// Circular FIFO that holds averaged SAR results until the consumer takes them.
module sar_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];

  // Fullness is judged before any same-cycle pop, so a push into a full FIFO is dropped.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sar_conv_sequencer.sv
// Periodic SAR conversion sequencer: sample timer, conversion FSM, averaging,
// sticky error flags and an output FIFO with a valid/ready handshake.
module sar_conv_sequencer
  import sar_pkg::*;
#(
  parameter int PERIOD_W   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 63
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [1:0]          avg_log2_i,
  output logic                cnvst_o,
  input  logic                eoc_i,
  input  logic [SAR_W-1:0]    sar_i,
  output logic [SAR_W-1:0]    out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o,
  output logic                err_ovr_o,
  output logic                err_late_o,
  output logic                err_tmo_o,
  input  logic                err_clr_i
);

  localparam int TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH + 1);

  seq_state_e          state_q, state_d;
  logic                en_q;
  logic [PERIOD_W-1:0] tmr_q, tmr_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          lat_q, lat_d;
  logic                err_ovr_q, err_late_q, err_tmo_q;
  logic                tick, push, tmo_evt, ovr_evt, late_evt;
  logic [CNT_W-1:0]    group_sz;
  logic                fifo_full, fifo_empty;
  logic [FCW-1:0]      fifo_count;

  // Holding the timer at 0 while disabled makes the first tick land one cycle after enable rises.
  always_comb begin
    tmr_d = tmr_q;
    if (!enable_i || !en_q) begin
      tmr_d = '0;
    end else if (tmr_q == '0) begin
      tmr_d = period_i;
    end else begin
      tmr_d = tmr_q - PERIOD_W'(1);
    end
  end

  assign tick     = enable_i && en_q && (tmr_q == '0);
  assign late_evt = tick && (state_q != ST_IDLE);
  assign group_sz = CNT_W'(1) << lat_q;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    push    = 1'b0;
    tmo_evt = 1'b0;
    ovr_evt = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tick) state_d = ST_START;
      end
      ST_START: begin
        tmo_d = TMO_W'(TIMEOUT);
        if (cnt_q == '0) lat_d = avg_log2_i;
        state_d = ST_CONV;
      end
      ST_CONV: begin
        if (eoc_i) begin
          acc_d   = acc_q + ACC_W'(sar_i);
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_d == group_sz) ? ST_PUSH : ST_IDLE;
        end else if (tmo_q <= TMO_W'(1)) begin
          // Out of time: the partial averaging group is thrown away.
          tmo_evt = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      ST_PUSH: begin
        push    = !fifo_full;
        ovr_evt = fifo_full;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      tmr_q   <= '0;
      tmo_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= enable_i;
      tmr_q   <= tmr_d;
      tmo_q   <= tmo_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end

  // Clearing wins over a set arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || err_clr_i) begin
      err_ovr_q  <= 1'b0;
      err_late_q <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      if (ovr_evt)  err_ovr_q  <= 1'b1;
      if (late_evt) err_late_q <= 1'b1;
      if (tmo_evt)  err_tmo_q  <= 1'b1;
    end
  end

  sar_result_fifo #(
    .WIDTH (SAR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (SAR_W'(acc_q >> lat_q)),
    .pop_i   (out_ready_i && !fifo_empty),
    .rdata_o (out_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_valid_o = (fifo_count != '0);
  assign cnvst_o     = (state_q == ST_START);
  assign busy_o      = (state_q != ST_IDLE);
  assign err_ovr_o   = err_ovr_q;
  assign err_late_o  = err_late_q;
  assign err_tmo_o   = err_tmo_q;

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Directed bench for sar_conv_sequencer with a behavioural SAR model and an
// expected-result queue checked against the samples the consumer accepts.
module tb_sar_conv_sequencer;

  localparam int PERIOD_W   = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 63;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                enable = 1'b0;
  logic [PERIOD_W-1:0] period = '0;
  logic [1:0]          avg_log2 = '0;
  logic                cnvst;
  logic                eoc = 1'b0;
  logic [7:0]          sar = '0;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic                busy;
  logic                err_ovr, err_late, err_tmo;
  logic                err_clr = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  sar_conv_sequencer #(
    .PERIOD_W   (PERIOD_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable),
    .period_i    (period),
    .avg_log2_i  (avg_log2),
    .cnvst_o     (cnvst),
    .eoc_i       (eoc),
    .sar_i       (sar),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy),
    .err_ovr_o   (err_ovr),
    .err_late_o  (err_late),
    .err_tmo_o   (err_tmo),
    .err_clr_i   (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SAR model: answers each cnvst with eoc mdl_delay cycles later, using queued values first.
  int         mdl_delay = 20;
  bit         mdl_mute = 1'b0;
  logic [7:0] mdl_default = 8'hA5;
  logic [7:0] mdl_table [64];
  int         mdl_fill = 0;
  int         mdl_served = 0;
  int         mdl_cnt = 0;
  int         eoc_cyc = -1;

  always @(negedge clk) begin
    eoc = 1'b0;
    if (mdl_cnt > 0) begin
      mdl_cnt = mdl_cnt - 1;
      if (mdl_cnt == 0) begin
        eoc     = 1'b1;
        eoc_cyc = cyc;
        sar     = (mdl_served < mdl_fill) ? mdl_table[mdl_served] : mdl_default;
        mdl_served = mdl_served + 1;
      end
    end
    if (cnvst && !mdl_mute) mdl_cnt = mdl_delay;
  end

  // Monitor: cnvst timing, out_valid rise, and every accepted output sample.
  int         cnv_total = 0;
  int         cnv_last = -1;
  int         cnv_gap = 0;
  int         vrise_cyc = -1;
  logic       prev_valid = 1'b0;
  logic [7:0] obs_mem [64];
  int         obs_wr = 0;

  always @(negedge clk) begin
    if (cnvst) begin
      if (cnv_last >= 0) cnv_gap = cyc - cnv_last;
      cnv_last  = cyc;
      cnv_total = cnv_total + 1;
    end
    if (out_valid && !prev_valid) vrise_cyc = cyc;
    prev_valid = out_valid;
    if (!rst && out_valid && out_ready && obs_wr < 64) begin
      obs_mem[obs_wr] = out_data;
      obs_wr = obs_wr + 1;
    end
  end

  logic [7:0] exp_q[$];
  int         obs_rd = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic en, input int per, input int avg, input logic rdy);
    enable    = en;
    period    = PERIOD_W'(per);
    avg_log2  = 2'(avg);
    out_ready = rdy;
  endtask

  task automatic mdlPush(input logic [7:0] v);
    if (mdl_fill < mdl_served) mdl_fill = mdl_served;
    if (mdl_fill < 64) begin
      mdl_table[mdl_fill] = v;
      mdl_fill = mdl_fill + 1;
    end
  endtask

  task automatic waitCnv(input int target, input int bound, input string tag);
    for (int i = 0; i < bound && cnv_total < target; i++) step(1);
    checkOutput(tag, 32'(cnv_total >= target), 32'd1);
  endtask

  task automatic waitIdle(input int bound, input string tag);
    for (int i = 0; i < bound && busy; i++) step(1);
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  task automatic pulseClear();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
  endtask

  task automatic checkScoreboard(input string tag);
    logic [7:0] want;
    logic [7:0] got;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      if (obs_rd < obs_wr) begin
        got    = obs_mem[obs_rd];
        obs_rd = obs_rd + 1;
      end else begin
        got = 8'hxx;
      end
      checkOutput(tag, 32'(got), 32'(want));
    end
    checkOutput({tag, "_count"}, 32'(obs_wr - obs_rd), 32'd0);
    obs_rd = obs_wr;
  endtask

  initial begin
    int t0, c0, o0, t_rst;

    // Reset state
    applyStimulus(1'b0, 0, 0, 1'b1);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
    checkOutput("rst_cnvst", 32'(cnvst), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_errs", 32'({err_ovr, err_late, err_tmo}), 32'd0);

    // Single-sample conversions at a 100-cycle period
    mdl_delay   = 20;
    mdl_default = 8'hA5;
    repeat (3) exp_q.push_back(8'hA5);
    c0 = cnv_total;
    applyStimulus(1'b1, 99, 0, 1'b1);
    t0 = cyc;
    waitCnv(c0 + 1, 10, "p1_first_cnvst");
    checkOutput("p1_enable_to_cnvst", 32'(cnv_last - t0), 32'd2);
    waitIdle(40, "p1_first_idle");
    step(2);
    checkOutput("p1_eoc_to_valid", 32'(vrise_cyc - eoc_cyc), 32'd2);
    waitCnv(c0 + 2, 120, "p1_second_cnvst");
    checkOutput("p1_period_gap", 32'(cnv_gap), 32'd100);
    waitCnv(c0 + 3, 120, "p1_third_cnvst");
    checkOutput("p1_period_gap2", 32'(cnv_gap), 32'd100);
    enable = 1'b0;
    waitIdle(60, "p1_idle");
    step(5);
    checkScoreboard("p1_data");
    checkOutput("p1_no_errs", 32'({err_ovr, err_late, err_tmo}), 32'd0);

    // Average of four, with avg_log2 changed mid-group
    mdlPush(8'h10);
    mdlPush(8'h11);
    mdlPush(8'h12);
    mdlPush(8'h14);
    exp_q.push_back(8'h11);
    c0 = cnv_total;
    o0 = obs_wr;
    applyStimulus(1'b1, 29, 2, 1'b1);
    waitCnv(c0 + 1, 10, "p2_first_cnvst");
    avg_log2 = 2'd0;
    waitCnv(c0 + 4, 200, "p2_fourth_cnvst");
    checkOutput("p2_no_early_out", 32'(obs_wr - o0), 32'd0);
    enable = 1'b0;
    waitIdle(60, "p2_idle");
    step(5);
    checkOutput("p2_cnvst_count", 32'(cnv_total - c0), 32'd4);
    checkScoreboard("p2_avg");

    // Six groups into a depth-4 FIFO with the consumer stalled
    for (int i = 0; i < 6; i++) mdlPush(8'(8'h31 + i));
    c0 = cnv_total;
    applyStimulus(1'b1, 29, 0, 1'b0);
    waitCnv(c0 + 4, 200, "p3_fourth_cnvst");
    waitIdle(40, "p3_idle4");
    checkOutput("p3_ovr_before", 32'(err_ovr), 32'd0);
    checkOutput("p3_valid", 32'(out_valid), 32'd1);
    checkOutput("p3_head", 32'(out_data), 32'h31);
    waitCnv(c0 + 5, 40, "p3_fifth_cnvst");
    waitIdle(40, "p3_idle5");
    checkOutput("p3_ovr_after5", 32'(err_ovr), 32'd1);
    waitCnv(c0 + 6, 40, "p3_sixth_cnvst");
    enable = 1'b0;
    waitIdle(40, "p3_idle6");
    checkOutput("p3_no_late", 32'(err_late), 32'd0);
    pulseClear();
    checkOutput("p3_ovr_cleared", 32'(err_ovr), 32'd0);
    checkOutput("p3_head_stable", 32'(out_data), 32'h31);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h31 + i));
    out_ready = 1'b1;
    step(8);
    checkScoreboard("p3_fifo_order");
    checkOutput("p3_drained", 32'(out_valid), 32'd0);

    // Conversion that never completes
    mdl_mute = 1'b1;
    c0 = cnv_total;
    applyStimulus(1'b1, 199, 0, 1'b1);
    waitCnv(c0 + 1, 10, "p4_cnvst");
    t0 = cnv_last;
    for (int i = 0; i < 100 && !err_tmo; i++) step(1);
    checkOutput("p4_tmo_set", 32'(err_tmo), 32'd1);
    checkOutput("p4_tmo_latency", 32'(cyc - t0), 32'(TIMEOUT + 1));
    checkOutput("p4_idle_after_tmo", 32'(busy), 32'd0);
    mdl_mute    = 1'b0;
    mdl_default = 8'h5A;
    exp_q.push_back(8'h5A);
    waitCnv(c0 + 2, 250, "p4_next_cnvst");
    enable = 1'b0;
    waitIdle(40, "p4_idle");
    step(3);
    checkScoreboard("p4_recover");
    checkOutput("p4_tmo_sticky", 32'(err_tmo), 32'd1);
    pulseClear();
    checkOutput("p4_tmo_cleared", 32'(err_tmo), 32'd0);

    // Ticks faster than a conversion
    mdl_default = 8'h77;
    repeat (2) exp_q.push_back(8'h77);
    c0 = cnv_total;
    applyStimulus(1'b1, 9, 0, 1'b1);
    waitCnv(c0 + 2, 80, "p5_second_cnvst");
    enable = 1'b0;
    checkOutput("p5_gap", 32'(cnv_gap), 32'd30);
    checkOutput("p5_late", 32'(err_late), 32'd1);
    waitIdle(40, "p5_idle");
    step(3);
    checkScoreboard("p5_data");
    pulseClear();
    checkOutput("p5_late_cleared", 32'(err_late), 32'd0);

    // Reset during a conversion with two samples queued
    mdl_delay = 40;
    c0 = cnv_total;
    o0 = obs_wr;
    applyStimulus(1'b1, 59, 0, 1'b0);
    waitCnv(c0 + 2, 150, "p6_second_cnvst");
    waitIdle(60, "p6_idle2");
    checkOutput("p6_queued", 32'(out_valid), 32'd1);
    waitCnv(c0 + 3, 80, "p6_third_cnvst");
    step(5);
    checkOutput("p6_busy_before", 32'(busy), 32'd1);
    rst    = 1'b1;
    enable = 1'b0;
    t_rst  = cyc;
    step(1);
    checkOutput("p6_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("p6_rst_busy", 32'(busy), 32'd0);
    checkOutput("p6_rst_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    step(50);
    checkOutput("p6_late_eoc_seen", 32'(eoc_cyc > t_rst), 32'd1);
    checkOutput("p6_late_eoc_busy", 32'(busy), 32'd0);
    checkOutput("p6_late_eoc_valid", 32'(out_valid), 32'd0);
    checkOutput("p6_no_output", 32'(obs_wr - o0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
